// File: rtl/apb_master_arb.sv
// Round-robin two-port APB master: one outstanding transfer, SETUP->ACCESS sequencing, registered outputs.
// Optional ACCESS watchdog built when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                win_c;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
`endif

    // Tie goes to the port that did not win last time
    always_comb begin
        win_c = (req0 && req1) ? ~last_grant_q : req1;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d        = '0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (req0 || req1) begin
                    grant_d  = win_c;
                    pwrite_d = win_c ? wr1 : wr0;
                    paddr_d  = win_c ? addr1 : addr0;
                    if (win_c ? wr1 : wr0) pwdata_d = win_c ? wdata1 : wdata0;
                    else                   pwdata_d = '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    if (!pwrite_q) begin
                        if (grant_q) rdata1_d = PRDATA;
                        else         rdata0_d = PRDATA;
                    end
                    state_d   = COMPLETE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Slave never answered: abort with done+err, read data left untouched
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    err0_d    = ~grant_q;
                    err1_d    = grant_q;
                    state_d   = COMPLETE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            COMPLETE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cnt_q  <= '0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    // TIMEOUT only matters when the watchdog is built
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: directed transfers, expected completions queued and checked by a monitor.
module tb_apb_master_arb;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [16];
    int          slave_waits = 0;
    bit          slave_hang = 0;
    int          acc_cnt = 0;

    apb_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: ready after slave_waits low ACCESS cycles, small memory
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = !slave_hang && (acc_cnt >= slave_waits);
            PRDATA = mem[PADDR[3:0]];
            if (PREADY && PWRITE) mem[PADDR[3:0]] = PWDATA;
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'hDEAD_BEEF;
            acc_cnt = 0;
        end
    end

    // Monitor: every completion pulse must match the head of the scoreboard
    always @(negedge PCLK) begin
        if (done0 === 1'b1 || done1 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'b0, done1, done0}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_onehot", 32'(done0 & done1), 32'h0);
                chk("done_port", 32'(done1), 32'(e.port));
                chk("done_cycle", cyc, e.cyc);
                chk("err", 32'(e.port ? err1 : err0), 32'(e.err));
                if (!e.wr && !e.err) chk("rdata", e.port ? rdata1 : rdata0, e.rdata);
            end
        end
    end

    task automatic xfer(input bit port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] exp_rdata, input bit exp_err);
        int c;
        int n;
        bit seen;
        bit unstable;
        bit other_moved;
        logic [31:0] pw;
        logic [31:0] other;
        exp_t e;
        pw = wr ? wdata : 32'h0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        slave_waits = waits;
        if (port) begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata; other = rdata0; end
        else      begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata; other = rdata1; end
        c = cyc;
        e.port = port; e.wr = wr; e.rdata = exp_rdata; e.err = exp_err; e.cyc = c + 3 + waits;
        sb.push_back(e);
        @(negedge PCLK);
        chk("setup_ctl", {30'b0, PSEL, PENABLE}, 32'h2);
        chk("setup_addr", PADDR, addr);
        chk("setup_wdata", PWDATA, pw);
        chk("setup_write", 32'(PWRITE), 32'(wr));
        @(negedge PCLK);
        chk("access_ctl", {30'b0, PSEL, PENABLE}, 32'h3);
        n = 0; seen = 0; unstable = 0; other_moved = 0;
        while (!seen && n < 40) begin
            if (PSEL && (PADDR !== addr || PWRITE !== wr || PWDATA !== pw)) unstable = 1;
            if ((port ? done1 : done0) === 1'b1) seen = 1;
            if ((port ? rdata0 : rdata1) !== other || (port ? done0 : done1) === 1'b1) other_moved = 1;
            if (!seen) begin
                @(negedge PCLK);
                n++;
            end
        end
        if (!seen) chk("done_wait_expired", 32'h0, 32'h1);
        @(negedge PCLK);
        chk("done_pulse", 32'(port ? done1 : done0), 32'h0);
        if (port) req1 = 1'b0; else req0 = 1'b0;
        chk("bus_stable", 32'(unstable), 32'h0);
        chk("other_port_hold", 32'(other_moved), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int k;
        int n0;
        int n1;
        bit pulse_bad;
        bit p0;
        bit p1;
        exp_t e;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        PRESETn = 1'b0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hA5A5_0001;
        req1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        PRDATA = 32'h0; PREADY = 1'b0;

        // Reset held two cycles with req0 pending
        repeat (2) begin
            @(negedge PCLK);
            chk("rst_ctl", {30'b0, PSEL, PENABLE}, 32'h0);
            chk("rst_done", {30'b0, done1, done0}, 32'h0);
            chk("rst_rdata0", rdata0, 32'h0);
        end

        // Write then read on port 0; write starts the cycle reset is released
        xfer(0, 1, 32'd5, 32'hA5A5_0001, 0, 32'h0, 0);
        xfer(0, 0, 32'd5, 32'h0, 0, 32'hA5A5_0001, 0);

        // Port-1 read with three wait states, done at N+6
        xfer(1, 0, 32'd7, 32'h0, 3, 32'h1000_0007, 0);
        chk("p0_rdata_kept", rdata0, 32'hA5A5_0001);

        // Both requesters held: grants alternate 0,1,0,1
        @(negedge PCLK);
        slave_waits = 0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd2;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'd3;
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            e.port = i[0]; e.wr = 1'b0; e.err = 1'b0; e.cyc = c + 3 + 4 * i;
            e.rdata = i[0] ? 32'h1000_0003 : 32'h1000_0002;
            sb.push_back(e);
        end
        n0 = 0; n1 = 0; k = 0; pulse_bad = 0; p0 = 0; p1 = 0;
        while ((n0 < 2 || n1 < 2) && k < 60) begin
            @(negedge PCLK);
            k++;
            if ((done0 && p0) || (done1 && p1)) pulse_bad = 1;
            p0 = done0; p1 = done1;
            if (done0) begin n0++; if (n0 == 2) req0 = 1'b0; end
            if (done1) begin n1++; if (n1 == 2) req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_done_count", 32'(n0 + n1), 32'd4);
        @(negedge PCLK);
        if ((done0 && p0) || (done1 && p1)) pulse_bad = 1;
        chk("tie_pulse_width", 32'(pulse_bad), 32'h0);

        // Reset asserted during ACCESS aborts without done
        @(negedge PCLK);
        slave_waits = 5;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'd9; wdata0 = 32'h1234_5678;
        repeat (2) @(negedge PCLK);
        chk("mr_in_access", {30'b0, PSEL, PENABLE}, 32'h3);
        PRESETn = 1'b0;
        @(negedge PCLK);
        chk("mr_ctl", {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
        chk("mr_paddr", PADDR, 32'h0);
        chk("mr_pwdata", PWDATA, 32'h0);
        chk("mr_rdata", rdata0 | rdata1, 32'h0);
        chk("mr_done", {30'b0, done1, done0}, 32'h0);
        req0 = 1'b0;
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("mr_idle", 32'(PSEL), 32'h0);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: done0+err0 after 4 ACCESS cycles, rdata0 untouched
        slave_hang = 1;
        xfer(0, 0, 32'd1, 32'h0, 3, 32'h0, 1);
        chk("to_rdata_hold", rdata0, 32'h0);
        slave_hang = 0;
`else
        // Slave never ready: master stays in ACCESS indefinitely
        slave_hang = 1;
        @(negedge PCLK);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd1;
        repeat (20) @(negedge PCLK);
        chk("hang_access", {30'b0, PSEL, PENABLE}, 32'h3);
        chk("hang_err", {30'b0, err1, err0}, 32'h0);
        PRESETn = 1'b0;
        @(negedge PCLK);
        req0 = 1'b0;
        PRESETn = 1'b1;
        slave_hang = 0;
        repeat (2) @(negedge PCLK);
`endif

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
